program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DEPTH, 16, number of 32-bit instruction words written to program memory.
REQ-002 Parameter WIDTH, 32, instruction word width in bits.
REQ-003 Parameter ADD_WIDTH, 4, program memory address width.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset.
REQ-006 Port start  input  1  single-cycle pulse that begins a load; honoured only in IDLE or DONE.
REQ-007 Port in_data  input  8  next program byte, little-endian within each word.
REQ-008 Port in_valid  input  1  in_data is valid this cycle.
REQ-009 Port in_ready  output  1  loader accepts in_data this cycle; a byte transfers when in_valid and in_ready are both high.
REQ-010 Port mem_wen  output  1  program memory write strobe, exactly one cycle wide per word.
REQ-011 Port mem_add  output  ADD_WIDTH  program memory write address.
REQ-012 Port mem_wdata  output  WIDTH  assembled instruction word.
REQ-013 Port cpu_rst  output  1  active-high hold for the CPU core; high while a load is in progress.
REQ-014 Port done  output  1  level; all DEPTH words have been written.
REQ-015 Port err  output  1  level; checksum mismatch (PROGRAM_LOADER_CHECKSUM_EN only, otherwise tied 0).

Function
REQ-016 FSM states: IDLE, COLLECT, WRITE, CHECK, DONE.
REQ-017 IDLE: in_ready=0, cpu_rst=1; start -> COLLECT, word counter and byte counter cleared.
REQ-018 COLLECT: in_ready=1; each accepted byte is shifted into the word at position byte_cnt*8; a 2-bit byte counter increments.
REQ-019 The fourth accepted byte -> WRITE on the next edge; in_ready is 0 in WRITE, so no byte is lost or doubled.
REQ-020 WRITE lasts one cycle: mem_wen=1, mem_add=word counter, mem_wdata=assembled word.
REQ-021 After WRITE: if word counter = DEPTH-1 -> CHECK (macro on) or DONE (macro off); otherwise counter+1 -> COLLECT.
REQ-022 Per-word latency: one cycle from the fourth byte handshake to mem_wen high.
REQ-023 in_valid low in COLLECT stalls the FSM indefinitely; partial word and counters hold.
REQ-024 DONE: done=1, cpu_rst=0, in_ready=0; start -> COLLECT (reload) with done cleared and cpu_rst=1 the same cycle the state changes.
REQ-025 start during COLLECT, WRITE or CHECK is ignored.
REQ-026 The word counter never wraps during a load; addresses 0..DEPTH-1 are each written exactly once per load.
REQ-027 mem_wen=0 in every state except WRITE; mem_add and mem_wdata are don't-care when mem_wen=0 but are registered.

Reset
REQ-028 rst low: state=IDLE, counters=0, assembled word=0, mem_wen=0, in_ready=0, done=0, err=0, cpu_rst=1.
REQ-029 rst asserted mid-load aborts immediately; any partial word is discarded and no write is issued.

Configuration
REQ-030 Macro PROGRAM_LOADER_CHECKSUM_EN defined: an 8-bit running sum (mod 256) of all program bytes is kept; CHECK accepts one extra byte; equal to sum -> DONE with err=0, otherwise DONE with err=1.
REQ-031 Macro undefined: no CHECK state, no checksum register, err tied 0, DONE entered directly after the last WRITE.
REQ-032 err clears on start and on reset; cpu_rst is released in DONE regardless of err.

Structure
REQ-033 Shared package risc_v_pkg holds the loader state enum and the constants INSTR_W=32 and BYTE_W=8.
REQ-034 One sub-module byte_assembler (byte shift-in, byte counter, word-complete flag); FSM and address counter stay in program_loader.

Verification
REQ-035 Reset, then start, then 64 bytes 0x00..0x3F with in_valid held high -> 16 writes; word 0 = 0x03020100, word 15 = 0x3F3E3D3C at add 15; then done=1, cpu_rst=0.
REQ-036 in_valid toggled 1-0-1-0 on each byte -> identical memory image; mem_wen pulses stay one cycle wide; no write while a word is incomplete.
REQ-037 rst low after 6 bytes, then a fresh full load -> the first write is at add 0 with data from new bytes only.
REQ-038 start pulses during COLLECT -> ignored; a start in DONE -> reload, done=0, cpu_rst=1 on the next cycle.
REQ-039 PROGRAM_LOADER_CHECKSUM_EN with bytes 0x00..0x3F plus checksum 0xE0 -> err=0; the same stream plus 0xE1 -> err=1, done=1.
REQ-040 Sustained in_valid -> exactly 5 cycles per word (4 COLLECT + 1 WRITE); a full load is 80 cycles from the first byte to the last mem_wen.

Source files
------------

// File: rtl/risc_v_pkg.sv
// Shared loader types and widths: FSM state encoding plus instruction/byte sizes.
package risc_v_pkg;

    localparam int INSTR_W = 32;
    localparam int BYTE_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DONE    = 3'd4
    } loader_state_e;

endpackage

// File: rtl/byte_assembler.sv
// Little-endian byte shift-in: places each accepted byte at lane byte_cnt and
// flags the handshake that completes a word.
module byte_assembler
    import risc_v_pkg::*;
#(
    parameter int WIDTH = INSTR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              shift_en_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WIDTH-1:0]  word_o,
    output logic              word_done_o
);

    localparam int LANES = WIDTH / BYTE_W;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             last_lane;

    assign last_lane = (byte_cnt_q == CNT_W'(LANES - 1));

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign word_d[gi*BYTE_W +: BYTE_W] =
                clear_i ? '0 :
                (shift_en_i && (byte_cnt_q == CNT_W'(gi))) ? byte_i :
                word_q[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if (clear_i) begin
            byte_cnt_d = '0;
        end else if (shift_en_i) begin
            byte_cnt_d = last_lane ? '0 : byte_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
        end
    end

    assign word_o      = word_q;
    assign word_done_o = shift_en_i && last_lane;

endmodule

// File: rtl/program_loader.sv
// Streams bytes into DEPTH program words and holds the CPU in reset until done.
// Optional trailing checksum byte enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
    import risc_v_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = INSTR_W,
    parameter int ADD_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BYTE_W-1:0]    in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 mem_wen,
    output logic [ADD_WIDTH-1:0] mem_add,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic                 cpu_rst,
    output logic                 done,
    output logic                 err
);

    localparam logic [ADD_WIDTH-1:0] LAST_ADD = ADD_WIDTH'(DEPTH - 1);

    loader_state_e        state_q, state_d;
    logic [ADD_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic                 load_start;
    logic                 byte_acc;
    logic                 word_done;
    logic [WIDTH-1:0]     word;

    assign byte_acc = in_valid && (state_q == ST_COLLECT);

    byte_assembler #(
        .WIDTH (WIDTH)
    ) u_byte_assembler (
        .clk         (clk),
        .rst_n       (rst),
        .clear_i     (load_start),
        .shift_en_i  (byte_acc),
        .byte_i      (in_data),
        .word_o      (word),
        .word_done_o (word_done)
    );

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        load_start = 1'b0;
        in_ready   = 1'b0;
        mem_wen    = 1'b0;
        cpu_rst    = 1'b1;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_start = 1'b1;
                    word_cnt_d = '0;
                    state_d    = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                in_ready = 1'b1;
                if (word_done) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_wen = 1'b1;
                if (word_cnt_q == LAST_ADD) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    state_d    = ST_COLLECT;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
                // Reload: outputs follow state, so done/cpu_rst flip on the same edge.
                if (start) begin
                    load_start = 1'b1;
                    word_cnt_d = '0;
                    state_d    = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign mem_add   = word_cnt_q;
    assign mem_wdata = word;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] sum_q, sum_d;
    logic              err_q, err_d;
    logic              check_acc;

    assign check_acc = in_valid && (state_q == ST_CHECK);

    always_comb begin
        sum_d = sum_q;
        err_d = err_q;
        if (load_start) begin
            sum_d = '0;
            err_d = 1'b0;
        end else begin
            if (byte_acc) begin
                sum_d = sum_q + in_data;
            end
            if (check_acc) begin
                err_d = (in_data != sum_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: full loads, stalls, ignored starts,
// mid-load reset, reload from DONE and (when enabled) checksum outcomes.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_wen;
    logic [3:0]  mem_add;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int vectors = 0;
    int miscompares = 0;
    int timeouts = 0;
    int mark = 0;

    // Monitor state, written only by the monitor process.
    int          cyc = 0;
    int          mark_seen = 0;
    int          wr_cnt = 0;
    int          wide_err = 0;
    int          first_hs_cyc = -1;
    int          first_wr_cyc = -1;
    int          last_wen_cyc = -1;
    logic [3:0]  first_wr_add = '0;
    logic [31:0] first_wr_data = '0;
    logic        prev_wen = 1'b0;
    logic [31:0] img [16];
    int          per_add [16];

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam logic EXP_ERR_BAD = 1'b1;
`else
    localparam logic EXP_ERR_BAD = 1'b0;
`endif

    program_loader dut (
        .clk       (clk),
        .rst       (rst_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_wen   (mem_wen),
        .mem_add   (mem_add),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        cyc++;
        if (mark != mark_seen) begin
            mark_seen    = mark;
            wr_cnt       = 0;
            wide_err     = 0;
            first_hs_cyc = -1;
            first_wr_cyc = -1;
            last_wen_cyc = -1;
            for (int i = 0; i < 16; i++) begin
                img[i]     = 32'h0;
                per_add[i] = 0;
            end
        end
        if (in_valid && in_ready && first_hs_cyc < 0) first_hs_cyc = cyc;
        if (mem_wen) begin
            if (first_wr_cyc < 0) begin
                first_wr_cyc  = cyc;
                first_wr_add  = mem_add;
                first_wr_data = mem_wdata;
            end
            img[mem_add] = mem_wdata;
            per_add[mem_add]++;
            wr_cnt++;
            last_wen_cyc = cyc;
            if (prev_wen) wide_err++;
        end
        prev_wen = mem_wen;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int base, input int w);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(base + 4*w);
        b1 = 8'(base + 4*w + 1);
        b2 = 8'(base + 4*w + 2);
        b3 = 8'(base + 4*w + 3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic int bad_words(input int base);
        int bad = 0;
        for (int w = 0; w < 16; w++)
            if (img[w] !== exp_word(base, w) || per_add[w] != 1) bad++;
        return bad;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offers one byte until accepted (bounded), then idles for gap cycles.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
        bit hs = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk); #1;
            if (hs) break;
        end
        if (!hs) timeouts++;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            start = with_start;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) break;
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_wen", 32'(mem_wen), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd0);
        check("idle_cpu_rst", 32'(cpu_rst), 32'd1);

        // A: continuous stream 0x00..0x3F
        @(posedge clk); #1;
        mark++;
        pulse_start();
        for (int i = 0; i < 64; i++) send_byte(8'(i), 0, 1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'hE0, 0, 1'b0);
`endif
        wait_done();
        check("A_done", 32'(done), 32'd1);
        check("A_cpu_rst", 32'(cpu_rst), 32'd0);
        check("A_in_ready", 32'(in_ready), 32'd0);
        check("A_mem_wen_done", 32'(mem_wen), 32'd0);
        check("A_err", 32'(err), 32'd0);
        check("A_writes", 32'(wr_cnt), 32'd16);
        check("A_word0", img[0], 32'h03020100);
        check("A_word15", img[15], 32'h3F3E3D3C);
        check("A_bad_words", 32'(bad_words(0)), 32'd0);
        check("A_wide_wen", 32'(wide_err), 32'd0);
        check("A_first_latency", 32'(first_wr_cyc - first_hs_cyc), 32'd4);
        check("A_load_cycles", 32'(last_wen_cyc - first_hs_cyc + 1), 32'd80);
        check("A_timeouts", 32'(timeouts), 32'd0);

        // B: reload from DONE, toggled valid, start pulses ignored mid-load
        @(posedge clk); #1;
        mark++;
        pulse_start();
        @(negedge clk);
        check("B_reload_done", 32'(done), 32'd0);
        check("B_reload_cpu_rst", 32'(cpu_rst), 32'd1);
        check("B_reload_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++)
            send_byte(8'(i), 1, (i == 7) || (i == 10) || (i == 37));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'hE1, 0, 1'b0);
`endif
        wait_done();
        check("B_done", 32'(done), 32'd1);
        check("B_cpu_rst", 32'(cpu_rst), 32'd0);
        check("B_err", 32'(err), 32'(EXP_ERR_BAD));
        check("B_writes", 32'(wr_cnt), 32'd16);
        check("B_bad_words", 32'(bad_words(0)), 32'd0);
        check("B_wide_wen", 32'(wide_err), 32'd0);
        check("B_timeouts", 32'(timeouts), 32'd0);

        // C: start from DONE clears err, reset after 6 bytes, fresh load
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        check("C_start_err", 32'(err), 32'd0);
        check("C_start_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) send_byte(8'(8'h40 + i), 0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("C_rst_in_ready", 32'(in_ready), 32'd0);
        check("C_rst_mem_wen", 32'(mem_wen), 32'd0);
        check("C_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("C_rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mark++;
        @(posedge clk); #1;
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            send_byte(8'(8'h80 + i), (i == 2) ? 20 : 0, 1'b0);
            if (i == 2) check("C_stall_no_write", 32'(wr_cnt), 32'd0);
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'hE0, 0, 1'b0);
`endif
        wait_done();
        check("C_first_add", 32'(first_wr_add), 32'd0);
        check("C_first_data", first_wr_data, 32'h83828180);
        check("C_word15", img[15], 32'hBFBEBDBC);
        check("C_bad_words", 32'(bad_words(8'h80)), 32'd0);
        check("C_writes", 32'(wr_cnt), 32'd16);
        check("C_done", 32'(done), 32'd1);
        check("C_err", 32'(err), 32'd0);
        check("C_timeouts", 32'(timeouts), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
